// File: rtl/address_read.sv
// address_read: hands out free packet-buffer ids to nine requesting ports.
// A round-robin arbiter picks one requester, pops an id from the free-id
// FIFO, returns it to the winning port and initialises that buffer's
// reference count with the number of output ports it will be sent to.
module address_read (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        i_pkt_bufid_req_p0,
  input  logic        i_pkt_bufid_req_p1,
  input  logic        i_pkt_bufid_req_p2,
  input  logic        i_pkt_bufid_req_p3,
  input  logic        i_pkt_bufid_req_p4,
  input  logic        i_pkt_bufid_req_p5,
  input  logic        i_pkt_bufid_req_p6,
  input  logic        i_pkt_bufid_req_p7,
  input  logic        i_pkt_bufid_req_p8,
  input  logic [3:0]  iv_outport_num_p0,
  input  logic [3:0]  iv_outport_num_p1,
  input  logic [3:0]  iv_outport_num_p2,
  input  logic [3:0]  iv_outport_num_p3,
  input  logic [3:0]  iv_outport_num_p4,
  input  logic [3:0]  iv_outport_num_p5,
  input  logic [3:0]  iv_outport_num_p6,
  input  logic [3:0]  iv_outport_num_p7,
  input  logic [3:0]  iv_outport_num_p8,
  output logic        o_pkt_bufid_ack_p0,
  output logic        o_pkt_bufid_ack_p1,
  output logic        o_pkt_bufid_ack_p2,
  output logic        o_pkt_bufid_ack_p3,
  output logic        o_pkt_bufid_ack_p4,
  output logic        o_pkt_bufid_ack_p5,
  output logic        o_pkt_bufid_ack_p6,
  output logic        o_pkt_bufid_ack_p7,
  output logic        o_pkt_bufid_ack_p8,
  output logic [8:0]  ov_pkt_bufid_p0,
  output logic [8:0]  ov_pkt_bufid_p1,
  output logic [8:0]  ov_pkt_bufid_p2,
  output logic [8:0]  ov_pkt_bufid_p3,
  output logic [8:0]  ov_pkt_bufid_p4,
  output logic [8:0]  ov_pkt_bufid_p5,
  output logic [8:0]  ov_pkt_bufid_p6,
  output logic [8:0]  ov_pkt_bufid_p7,
  output logic [8:0]  ov_pkt_bufid_p8,
  output logic        o_free_bufid_rd,
  input  logic [8:0]  iv_free_bufid,
  input  logic        i_free_bufid_empty,
  output logic [8:0]  ov_init_bufid_addr,
  output logic [3:0]  ov_init_outport_num,
  output logic        o_init_bufid_wr,
  output logic [1:0]  ov_address_read_state,
  output logic [15:0] ov_alloc_stall_cnt
);

  typedef enum logic [1:0] {
    SCAN_S    = 2'd0,
    RD_WAIT_S = 2'd1,
    GRANT_S   = 2'd2,
    CLR_S     = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Request and count vectors padded so a 4-bit index can never fall outside them.
  logic [15:0] req_ext;
  logic [63:0] num_flat;

  logic [4:0]  cand;
  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  win_num;

  logic        rd_reg;
  logic        rd_next;
  logic [8:0]  ack_reg;
  logic [8:0]  ack_next;
  logic        wr_reg;
  logic        wr_next;
  logic        latch_en;
  logic        grant_en;
  logic        stall_inc;

  logic [3:0]  rr_ptr_reg;
  logic [3:0]  win_idx_reg;
  logic [3:0]  win_num_reg;
  logic [8:0]  addr_reg;
  logic [3:0]  data_reg;
  logic [15:0] stall_reg;
  logic [80:0] bufid_flat;

  assign req_ext = {7'd0,
                    i_pkt_bufid_req_p8, i_pkt_bufid_req_p7, i_pkt_bufid_req_p6,
                    i_pkt_bufid_req_p5, i_pkt_bufid_req_p4, i_pkt_bufid_req_p3,
                    i_pkt_bufid_req_p2, i_pkt_bufid_req_p1, i_pkt_bufid_req_p0};

  assign num_flat = {28'd0,
                     iv_outport_num_p8, iv_outport_num_p7, iv_outport_num_p6,
                     iv_outport_num_p5, iv_outport_num_p4, iv_outport_num_p3,
                     iv_outport_num_p2, iv_outport_num_p1, iv_outport_num_p0};

  // Round-robin search: first requester at or above rr_ptr, wrapping 8 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    win_num   = 4'd0;
    cand      = 5'd0;
    for (int k = 0; k < 9; k++) begin
      cand = {1'b0, rr_ptr_reg} + 5'(k);
      if (cand >= 5'd9) begin
        cand = cand - 5'd9;
      end
      if (!win_found && req_ext[cand[3:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[3:0];
        win_num   = num_flat[{cand[3:0], 2'b00} +: 4];
      end
    end
  end

  // Next-state and next-output decode; every grant is a fixed four-cycle walk.
  always_comb begin
    state_next = state_reg;
    rd_next    = 1'b0;
    ack_next   = 9'd0;
    wr_next    = 1'b0;
    latch_en   = 1'b0;
    grant_en   = 1'b0;
    stall_inc  = 1'b0;
    case (state_reg)
      SCAN_S: begin
        if (win_found) begin
          if (i_free_bufid_empty) begin
            stall_inc = 1'b1;
          end else begin
            rd_next    = 1'b1;
            latch_en   = 1'b1;
            state_next = RD_WAIT_S;
          end
        end
      end
      RD_WAIT_S: begin
        state_next = GRANT_S;
      end
      GRANT_S: begin
        ack_next   = 9'd1 << win_idx_reg;
        wr_next    = 1'b1;
        grant_en   = 1'b1;
        state_next = CLR_S;
      end
      CLR_S: begin
        // Idle cycle so the granted port can drop its request before rescanning.
        state_next = SCAN_S;
      end
      default: begin
        state_next = SCAN_S;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg <= SCAN_S;
    end else begin
      state_reg <= state_next;
    end
  end

  // Registered strobes: FIFO read, per-port ack and RAM write enable.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_reg  <= 1'b0;
      ack_reg <= 9'd0;
      wr_reg  <= 1'b0;
    end else begin
      rd_reg  <= rd_next;
      ack_reg <= ack_next;
      wr_reg  <= wr_next;
    end
  end

  // Winner latch at pop time; a zero outport count is stored as one.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      win_idx_reg <= 4'd0;
      win_num_reg <= 4'd0;
    end else if (latch_en) begin
      win_idx_reg <= win_idx;
      win_num_reg <= (win_num == 4'd0) ? 4'd1 : win_num;
    end
  end

  // Grant-time updates: RAM write address/data and the round-robin pointer.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_reg   <= 9'd0;
      data_reg   <= 4'd0;
      rr_ptr_reg <= 4'd0;
    end else if (grant_en) begin
      addr_reg   <= iv_free_bufid;
      data_reg   <= win_num_reg;
      rr_ptr_reg <= (win_idx_reg == 4'd8) ? 4'd0 : win_idx_reg + 4'd1;
    end
  end

  // Saturating count of scan cycles spent waiting on an empty FIFO.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stall_reg <= 16'd0;
    end else if (stall_inc && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  // Per-port id holding registers; only the granted port's copy changes.
  for (genvar gi = 0; gi < 9; gi++) begin : g_port
    logic [8:0] id_reg;

    // Capture the popped id for this port on its grant, hold otherwise.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        id_reg <= 9'd0;
      end else if (grant_en && (win_idx_reg == 4'(gi))) begin
        id_reg <= iv_free_bufid;
      end
    end

    assign bufid_flat[gi*9 +: 9] = id_reg;
  end

  assign o_pkt_bufid_ack_p0 = ack_reg[0];
  assign o_pkt_bufid_ack_p1 = ack_reg[1];
  assign o_pkt_bufid_ack_p2 = ack_reg[2];
  assign o_pkt_bufid_ack_p3 = ack_reg[3];
  assign o_pkt_bufid_ack_p4 = ack_reg[4];
  assign o_pkt_bufid_ack_p5 = ack_reg[5];
  assign o_pkt_bufid_ack_p6 = ack_reg[6];
  assign o_pkt_bufid_ack_p7 = ack_reg[7];
  assign o_pkt_bufid_ack_p8 = ack_reg[8];

  assign ov_pkt_bufid_p0 = bufid_flat[8:0];
  assign ov_pkt_bufid_p1 = bufid_flat[17:9];
  assign ov_pkt_bufid_p2 = bufid_flat[26:18];
  assign ov_pkt_bufid_p3 = bufid_flat[35:27];
  assign ov_pkt_bufid_p4 = bufid_flat[44:36];
  assign ov_pkt_bufid_p5 = bufid_flat[53:45];
  assign ov_pkt_bufid_p6 = bufid_flat[62:54];
  assign ov_pkt_bufid_p7 = bufid_flat[71:63];
  assign ov_pkt_bufid_p8 = bufid_flat[80:72];

  assign o_free_bufid_rd       = rd_reg;
  assign o_init_bufid_wr       = wr_reg;
  assign ov_init_bufid_addr    = addr_reg;
  assign ov_init_outport_num   = data_reg;
  assign ov_address_read_state = state_reg;
  assign ov_alloc_stall_cnt    = stall_reg;

endmodule
